// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one SPI master between NUM_REQ requesters.
// An owner keeps the bus across back-to-back transactions until it drops req or idles out.
module spi_bus_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     req_snd,
  input  logic [16*NUM_REQ-1:0]  req_cmd,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     req_done,
  output logic [15:0]            resp,
  output logic                   timeout,
  output logic                   m_snd,
  output logic [15:0]            m_cmd,
  input  logic                   m_done,
  input  logic [15:0]            m_resp,
  input  logic                   m_ss_n,
  output logic [NUM_REQ-1:0]     ss_n
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_BUSY} state_e;

  state_e             state_q, state_d;
  logic [1:0]         owner_q, owner_d;
  logic [1:0]         rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic               timeout_q, timeout_d;
  logic               done_fire;

  logic [3:0]  req_pad, snd_pad;
  logic [63:0] cmd_pad;
  logic [1:0]  pick;
  logic        found;
  logic [1:0]  owner_next;

  assign req_pad    = 4'(req);
  assign snd_pad    = 4'(req_snd);
  assign cmd_pad    = 64'(req_cmd);
  assign owner_next = (owner_q == 2'(NUM_REQ - 1)) ? 2'd0 : owner_q + 2'd1;

  // Search upward from rr_ptr with wrap; iterating downward leaves the nearest hit last.
  always_comb begin
    logic [2:0] slot;
    pick  = 2'd0;
    found = 1'b0;
    slot  = 3'd0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      slot = {1'b0, rr_ptr_q} + 3'(k);
      if (slot >= 3'(NUM_REQ)) slot = slot - 3'(NUM_REQ);
      if (req_pad[slot[1:0]]) begin
        pick  = slot[1:0];
        found = 1'b1;
      end
    end
  end

  always_comb begin
    // NOTE: every variable gets a default up front so no path can infer a latch.
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    gnt_d      = gnt_q;
    idle_cnt_d = idle_cnt_q;
    timeout_d  = 1'b0;
    m_snd      = 1'b0;
    done_fire  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          owner_d    = pick;
          gnt_d      = NUM_REQ'(4'b0001 << pick);
          idle_cnt_d = '0;
          state_d    = S_GRANT;
        end
      end
      S_GRANT: begin
        if (req_pad[owner_q] && snd_pad[owner_q]) begin
          m_snd      = 1'b1;
          idle_cnt_d = '0;
          state_d    = S_BUSY;
        end else if (!req_pad[owner_q]) begin
          gnt_d    = '0;
          rr_ptr_d = owner_next;
          state_d  = S_IDLE;
        end else if (idle_cnt_q == CNT_W'(TIMEOUT - 1)) begin
          timeout_d  = 1'b1;
          gnt_d      = '0;
          rr_ptr_d   = owner_next;
          idle_cnt_d = '0;
          state_d    = S_IDLE;
        end else begin
          idle_cnt_d = idle_cnt_q + CNT_W'(1);
        end
      end
      S_BUSY: begin
        idle_cnt_d = '0;
        if (m_done) begin
          done_fire = 1'b1;
          state_d   = S_GRANT;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      owner_q    <= 2'd0;
      rr_ptr_q   <= 2'd0;
      gnt_q      <= '0;
      idle_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_q      <= gnt_d;
      idle_cnt_q <= idle_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // gnt is the one-hot owner, so it doubles as the routing mask for done and slave select.
  assign gnt      = gnt_q;
  assign req_done = done_fire ? gnt_q : '0;
  assign ss_n     = ~gnt_q | {NUM_REQ{m_ss_n}};
  assign timeout  = timeout_q;
  assign m_cmd    = cmd_pad[{owner_q, 4'b0000} +: 16];
  assign resp     = m_resp;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter: two requesters, short watchdog.
module tb_spi_bus_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req, req_snd, gnt, req_done, ss_n;
  logic [31:0] req_cmd;
  logic [15:0] resp, m_cmd, m_resp;
  logic        timeout, m_snd, m_done, m_ss_n;

  int errors = 0;
  int checks = 0;

  spi_bus_arbiter #(.NUM_REQ(2), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_snd(req_snd), .req_cmd(req_cmd),
    .gnt(gnt), .req_done(req_done), .resp(resp), .timeout(timeout),
    .m_snd(m_snd), .m_cmd(m_cmd), .m_done(m_done), .m_resp(m_resp),
    .m_ss_n(m_ss_n), .ss_n(ss_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; req_snd = '0; req_cmd = '0;
    m_done = 1'b0; m_resp = '0; m_ss_n = 1'b1;
    #1;
    checks++;
    if (gnt !== 2'b00 || ss_n !== 2'b11 || timeout !== 1'b0 || m_snd !== 1'b0 || req_done !== 2'b00) begin
      errors++;
      $display("FAIL reset_state: gnt=%b ss_n=%b timeout=%b m_snd=%b req_done=%b, want 00 11 0 0 00",
               gnt, ss_n, timeout, m_snd, req_done);
    end
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    req = 2'b01; #1;
    checks++;
    if (gnt !== 2'b00) begin errors++; $display("FAIL basic_gnt_latency: gnt=%b want 00", gnt); end
    step();
    checks++;
    if (gnt !== 2'b01) begin errors++; $display("FAIL basic_gnt: gnt=%b want 01", gnt); end
    m_ss_n = 1'b0; req_snd = 2'b01; req_cmd[15:0] = 16'h0800; req_cmd[31:16] = 16'h1234; #1;
    checks++;
    if (m_snd !== 1'b1 || m_cmd !== 16'h0800 || ss_n !== 2'b10) begin
      errors++;
      $display("FAIL basic_send: m_snd=%b m_cmd=%h ss_n=%b want 1 0800 10", m_snd, m_cmd, ss_n);
    end
    step();
    #1;
    checks++;
    if (m_snd !== 1'b0 || m_cmd !== 16'h0800) begin
      errors++; $display("FAIL basic_busy_snd_ignored: m_snd=%b m_cmd=%h want 0 0800", m_snd, m_cmd);
    end
    req_snd = 2'b00; m_done = 1'b1; m_resp = 16'h0ABC; #1;
    checks++;
    if (req_done !== 2'b01 || resp !== 16'h0ABC || ss_n[1] !== 1'b1) begin
      errors++;
      $display("FAIL basic_done: req_done=%b resp=%h ss_n=%b want 01 0abc 1x", req_done, resp, ss_n);
    end
    step();
    m_done = 1'b0; m_ss_n = 1'b1; #1;
    checks++;
    if (req_done !== 2'b00 || gnt !== 2'b01 || ss_n !== 2'b11) begin
      errors++;
      $display("FAIL basic_after_done: req_done=%b gnt=%b ss_n=%b want 00 01 11", req_done, gnt, ss_n);
    end
  endtask

  task automatic test_round_robin();
    req = 2'b11;
    step();
    checks++;
    if (gnt !== 2'b01) begin errors++; $display("FAIL rr_first: gnt=%b want 01", gnt); end
    req = 2'b10;
    step();
    checks++;
    if (gnt !== 2'b00) begin errors++; $display("FAIL rr_release_gap: gnt=%b want 00", gnt); end
    step();
    checks++;
    if (gnt !== 2'b10) begin errors++; $display("FAIL rr_second: gnt=%b want 10", gnt); end
    req = 2'b11;
    step();
    checks++;
    if (gnt !== 2'b10) begin errors++; $display("FAIL rr_hold: gnt=%b want 10", gnt); end
    req = 2'b01;
    step(); step();
    checks++;
    if (gnt !== 2'b01) begin errors++; $display("FAIL rr_alternate: gnt=%b want 01", gnt); end
    // Owner 0 releases; both request during IDLE, pointer now favours 1.
    req = 2'b10;
    step();
    req = 2'b11;
    step();
    checks++;
    if (gnt !== 2'b10) begin errors++; $display("FAIL rr_pointer: gnt=%b want 10", gnt); end
    req = 2'b00;
    step(); step();
  endtask

  task automatic test_back_to_back();
    req = 2'b01;
    step();
    req_snd = 2'b01; req_cmd[15:0] = 16'h00A1; #1;
    checks++;
    if (m_snd !== 1'b1 || m_cmd !== 16'h00A1) begin
      errors++; $display("FAIL b2b_send1: m_snd=%b m_cmd=%h want 1 00a1", m_snd, m_cmd);
    end
    step();
    req_snd = 2'b00; req = 2'b11; m_done = 1'b1; m_resp = 16'h1111; #1;
    checks++;
    if (req_done !== 2'b01) begin errors++; $display("FAIL b2b_done1: req_done=%b want 01", req_done); end
    step();
    m_done = 1'b0;
    req_snd = 2'b01; req_cmd[15:0] = 16'h00B2; #1;
    checks++;
    if (gnt !== 2'b01 || m_snd !== 1'b1 || m_cmd !== 16'h00B2) begin
      errors++;
      $display("FAIL b2b_send2: gnt=%b m_snd=%b m_cmd=%h want 01 1 00b2", gnt, m_snd, m_cmd);
    end
    step();
    req_snd = 2'b00; m_done = 1'b1; m_resp = 16'h2222; #1;
    checks++;
    if (req_done !== 2'b01 || resp !== 16'h2222) begin
      errors++; $display("FAIL b2b_done2: req_done=%b resp=%h want 01 2222", req_done, resp);
    end
    step();
    m_done = 1'b0; #1;
    checks++;
    if (gnt !== 2'b01) begin errors++; $display("FAIL b2b_keep: gnt=%b want 01", gnt); end
    req = 2'b10;
    step(); step();
    checks++;
    if (gnt !== 2'b10) begin errors++; $display("FAIL b2b_handover: gnt=%b want 10", gnt); end
    req = 2'b00;
    step(); step();
  endtask

  task automatic test_timeout();
    req = 2'b01;
    step();
    for (int c = 1; c <= 15; c++) step();
    checks++;
    if (gnt !== 2'b01 || timeout !== 1'b0) begin
      errors++; $display("FAIL to_early: gnt=%b timeout=%b want 01 0", gnt, timeout);
    end
    step();
    checks++;
    if (gnt !== 2'b00 || timeout !== 1'b1) begin
      errors++; $display("FAIL to_fire: gnt=%b timeout=%b want 00 1", gnt, timeout);
    end
    step();
    checks++;
    if (gnt !== 2'b01 || timeout !== 1'b0) begin
      errors++; $display("FAIL to_regrant_self: gnt=%b timeout=%b want 01 0", gnt, timeout);
    end
    req = 2'b11;
    for (int c = 1; c <= 16; c++) step();
    checks++;
    if (gnt !== 2'b00 || timeout !== 1'b1) begin
      errors++; $display("FAIL to_fire2: gnt=%b timeout=%b want 00 1", gnt, timeout);
    end
    step();
    checks++;
    if (gnt !== 2'b10) begin errors++; $display("FAIL to_regrant_other: gnt=%b want 10", gnt); end
    req = 2'b00;
    step(); step();
  endtask

  task automatic test_ignored();
    req = 2'b01;
    step();
    req_snd = 2'b10; req_cmd[31:16] = 16'hFFFF; m_done = 1'b1; #1;
    checks++;
    if (m_snd !== 1'b0 || req_done !== 2'b00) begin
      errors++; $display("FAIL ign_nonowner: m_snd=%b req_done=%b want 0 00", m_snd, req_done);
    end
    step();
    req_snd = 2'b00; m_done = 1'b0;
    req = 2'b00; req_snd = 2'b01; #1;
    checks++;
    if (m_snd !== 1'b0) begin errors++; $display("FAIL ign_snd_release: m_snd=%b want 0", m_snd); end
    step();
    req_snd = 2'b00; m_done = 1'b1; #1;
    checks++;
    if (gnt !== 2'b00 || req_done !== 2'b00) begin
      errors++; $display("FAIL ign_done_idle: gnt=%b req_done=%b want 00 00", gnt, req_done);
    end
    step();
    m_done = 1'b0;
    checks++;
    if (gnt !== 2'b00) begin errors++; $display("FAIL ign_idle_stay: gnt=%b want 00", gnt); end
  endtask

  task automatic test_reset_busy();
    req = 2'b01;
    step();
    req_snd = 2'b01;
    step();
    req_snd = 2'b00; m_ss_n = 1'b0; #1;
    checks++;
    if (ss_n !== 2'b10) begin errors++; $display("FAIL rb_ss_busy: ss_n=%b want 10", ss_n); end
    m_done = 1'b1; rst_n = 1'b0; #1;
    checks++;
    if (gnt !== 2'b00 || ss_n !== 2'b11 || m_snd !== 1'b0 || req_done !== 2'b00) begin
      errors++;
      $display("FAIL rb_async: gnt=%b ss_n=%b m_snd=%b req_done=%b want 00 11 0 00", gnt, ss_n, m_snd, req_done);
    end
    m_done = 1'b0; m_ss_n = 1'b1; req = 2'b00;
    step();
    rst_n = 1'b1; req = 2'b10;
    step();
    checks++;
    if (gnt !== 2'b10) begin errors++; $display("FAIL rb_regrant: gnt=%b want 10", gnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reset();
    test_round_robin();
    test_reset();
    test_back_to_back();
    test_reset();
    test_timeout();
    test_reset();
    test_ignored();
    test_reset();
    test_reset_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
